seq_detect_fsm: RTL and testbench

Parametrised serial pattern detector. It is the successor to the fixed 5-state detector FSMs and has a runtime-programmable pattern, pattern length, and overlap mode. Each cycle with x_valid high it consumes one bit, then flags each pattern match and counts matches. It sits between serial bit sources and control logic within a single clock domain.

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/sat_counter.sv | 19 +
 rtl/seq_detect_fsm.sv | 125 ++++++++++++
 tb/tb_seq_detect_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared types and reset helpers for the serial pattern detector.
package seq_detect_pkg;

   typedef enum logic [0:0] {IDLE, RUN} state_t;

   // Overlapping matches are allowed out of reset.
   localparam logic OVERLAP_RST = 1'b1;

   // Out of reset the detector matches on the full pattern width.
   function automatic int len_rst_val(input int pat_w);
      return pat_w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Count increments, holding at the maximum instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: runtime-programmable serial pattern detector.
// Optional build macro SEQ_DET_MEALY_EN: when defined, y is a combinational
// Mealy output in the same cycle as the completing bit; otherwise y is a
// registered pulse one cycle after it. match_cnt timing is the same either way.
module seq_detect_fsm
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             x_valid,
   input  logic             x,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed,
   output logic [LEN_W-1:0] fill
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(len_rst_val(PAT_W));

   state_t           state;
   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic             ovl_q;
   logic [LEN_W-1:0] fill_q;

   logic             cfg_ok;
   logic             consume;
   logic             match;
   logic [PAT_W-1:0] hist_nxt;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill_nxt;

   // An out-of-range length makes the whole write a no-op.
   assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_MAX);
   // A config strobe (legal or not) always steals the bit in that cycle.
   assign consume  = (state == RUN) && en && x_valid && !cfg_we;
   assign hist_nxt = {hist[PAT_W-2:0], x};
   assign fill_nxt = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);

   // Select the low len bits of the history for comparison.
   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++)
         mask[i] = (LEN_W'(i) < len_q);
   end

   assign match = consume && (fill_nxt >= len_q) &&
                  (((hist_nxt ^ pat_q) & mask) == '0);

   // Control FSM plus config, history and fill registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         hist   <= '0;
         fill_q <= '0;
         pat_q  <= '0;
         len_q  <= LEN_RST;
         ovl_q  <= OVERLAP_RST;
      end else if (cfg_we) begin
         // Illegal writes freeze everything for the cycle.
         if (cfg_ok) begin
            pat_q  <= cfg_pattern;
            len_q  <= cfg_len;
            ovl_q  <= cfg_overlap;
            hist   <= '0;
            fill_q <= '0;
            if (state == RUN && !en)
               state <= IDLE;
         end
      end else begin
         case (state)
            IDLE: if (en) state <= RUN;
            RUN: begin
               if (!en) begin
                  // History is kept; clearing fill is enough to forget it.
                  state  <= IDLE;
                  fill_q <= '0;
               end else if (x_valid) begin
                  hist   <= hist_nxt;
                  fill_q <= (match && !ovl_q) ? '0 : fill_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SEQ_DET_MEALY_EN
   assign y = match;
`else
   logic y_q;

   // Registered match pulse, one cycle after the completing bit.
   always_ff @(posedge clk) begin
      if (rst)
         y_q <= 1'b0;
      else
         y_q <= match;
   end

   assign y = y_q;
`endif

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (match),
      .cnt (match_cnt)
   );

   assign armed = (state == RUN);
   assign fill  = fill_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb_seq_detect_fsm: directed bench with a queue-based reference model.
module tb_seq_detect_fsm;

   localparam int PAT_W = 8;
   localparam int CNT_W = 2;
   localparam int LEN_W = $clog2(PAT_W) + 1;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             cfg_we = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             cfg_overlap = 1'b0;
   logic             x_valid = 1'b0;
   logic             x = 1'b0;
   logic             y;
   logic [CNT_W-1:0] match_cnt;
   logic             armed;
   logic [LEN_W-1:0] fill;

   always #5 clk = ~clk;

   seq_detect_fsm #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .x_valid     (x_valid),
      .x           (x),
      .y           (y),
      .match_cnt   (match_cnt),
      .armed       (armed),
      .fill        (fill)
   );

   int errs = 0;
   int checks = 0;
   bit started = 0;
   int nbits = 0;
   int ypos[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: bit queue (newest at back), plain integer counters.
   bit             m_run;
   bit             mh[$];
   int             m_fill, m_len, m_cnt;
   bit [PAT_W-1:0] m_pat;
   bit             m_ovl, m_y;

   function automatic bit model_match(input bit b);
      int fn;
      fn = (m_fill + 1 > PAT_W) ? PAT_W : m_fill + 1;
      if (fn < m_len) return 1'b0;
      if (b != m_pat[0]) return 1'b0;
      for (int k = 1; k < m_len; k++) begin
         if (mh.size() < k) return 1'b0;
         if (mh[mh.size() - k] != m_pat[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      bit hit;
      m_y = 1'b0;
      if (rst) begin
         m_run = 0; mh.delete(); m_fill = 0; m_cnt = 0;
         m_pat = '0; m_len = PAT_W; m_ovl = 1'b1;
      end else if (cfg_we) begin
         if (cfg_len >= 1 && cfg_len <= PAT_W) begin
            m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap;
            mh.delete(); m_fill = 0;
            if (!en) m_run = 0;
         end
      end else if (!m_run) begin
         m_run = en;
      end else if (!en) begin
         m_run = 0; m_fill = 0;
      end else if (x_valid) begin
         hit = model_match(x);
         mh.push_back(x);
         if (mh.size() > PAT_W) void'(mh.pop_front());
         m_fill = (m_fill + 1 > PAT_W) ? PAT_W : m_fill + 1;
         if (hit) begin
            m_y = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
            if (!m_ovl) m_fill = 0;
         end
      end
   end

   // Per-cycle comparison against the model, plus y-position capture.
   always @(negedge clk) begin
      if (started) begin
         bit yexp;
`ifdef SEQ_DET_MEALY_EN
         yexp = m_run && en && !cfg_we && x_valid && !rst && model_match(x);
`else
         yexp = m_y;
`endif
         chk("cmp_y", 32'(y), 32'(yexp));
         chk("cmp_cnt", 32'(match_cnt), 32'(m_cnt));
         chk("cmp_armed", 32'(armed), 32'(m_run));
         chk("cmp_fill", 32'(fill), 32'(m_fill));
         if (y === 1'b1) begin
`ifdef SEQ_DET_MEALY_EN
            ypos.push_back(nbits + 1);
`else
            ypos.push_back(nbits);
`endif
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_rst();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
      cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic send_seq(input int s[]);
      foreach (s[i]) begin
         x = s[i][0]; x_valid = 1'b1;
         tick();
         nbits++;
      end
      x_valid = 1'b0;
   endtask

   task automatic begin_seg();
      nbits = 0; ypos.delete();
   endtask

   task automatic chk_ypos(input string nm, input int exp[]);
      chk({nm, "_npulse"}, 32'(ypos.size()), 32'(exp.size()));
      foreach (exp[i])
         if (i < ypos.size()) chk({nm, "_pos"}, 32'(ypos[i]), 32'(exp[i]));
   endtask

   initial begin
      tick(2);
      started = 1;
      rst = 1'b0;
      chk("rst_y", 32'(y), 0);
      chk("rst_cnt", 32'(match_cnt), 0);
      chk("rst_armed", 32'(armed), 0);
      chk("rst_fill", 32'(fill), 0);

      // 1: overlapping 1011
      cfg(8'b1011, 4'd4, 1'b1);
      en = 1'b1; tick();
      begin_seg();
      send_seq('{1, 0, 1, 1, 0, 1, 1});
      tick(2);
      chk_ypos("t1", '{4, 7});
      chk("t1_cnt", 32'(match_cnt), 2);
      chk("t1_fill", 32'(fill), 7);

      // 2: non-overlapping, same stream
      en = 1'b0; do_rst();
      cfg(8'b1011, 4'd4, 1'b0);
      en = 1'b1; tick();
      begin_seg();
      send_seq('{1, 0, 1, 1, 0, 1, 1});
      tick(2);
      chk_ypos("t2", '{4});
      chk("t2_cnt", 32'(match_cnt), 1);
      chk("t2_fill", 32'(fill), 3);

      // 3: single-bit pattern, counter saturation
      en = 1'b0; do_rst();
      cfg(8'b1, 4'd1, 1'b1);
      en = 1'b1; tick();
      begin_seg();
      send_seq('{1, 1, 1, 1, 1, 1});
      tick(2);
      chk_ypos("t3", '{1, 2, 3, 4, 5, 6});
      chk("t3_cnt", 32'(match_cnt), 3);

      // 4: reset mid-pattern, then illegal length write
      en = 1'b0; do_rst();
      cfg(8'b101, 4'd3, 1'b1);
      en = 1'b1; tick();
      begin_seg();
      send_seq('{1, 0});
      do_rst();
      tick();
      send_seq('{1});
      tick();
      chk("t4_noy", 32'(ypos.size()), 0);
      chk("t4_fill", 32'(fill), 1);
      chk("t4_cnt", 32'(match_cnt), 0);
      cfg(8'b101, 4'd3, 1'b1);
      begin_seg();
      send_seq('{1, 0});
      cfg(8'hFF, 4'd0, 1'b0);
      chk("t4_badcfg_fill", 32'(fill), 2);
      send_seq('{1});
      tick(2);
      chk_ypos("t4", '{3});
      chk("t4_cnt2", 32'(match_cnt), 1);

      // 5: config beats a bit; en drop mid-pattern
      en = 1'b0; do_rst();
      cfg(8'b1011, 4'd4, 1'b1);
      en = 1'b1; tick();
      begin_seg();
      send_seq('{1, 0});
      x = 1'b1; x_valid = 1'b1; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0; x_valid = 1'b0;
      chk("t5_drop_fill", 32'(fill), 0);
      send_seq('{1, 0});
      en = 1'b0; tick();
      chk("t5_armed_off", 32'(armed), 0);
      chk("t5_fill_off", 32'(fill), 0);
      en = 1'b1; tick();
      chk("t5_armed_on", 32'(armed), 1);
      begin_seg();
      send_seq('{1, 1, 0, 1, 1});
      tick(2);
      chk_ypos("t5", '{5});
      chk("t5_cnt", 32'(match_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
